// File: rtl/spin_commit_unit.sv
// Spin commit unit: accepts candidate spin vectors, discards non-improving ones,
// and writes accepted vectors out word by word while tracking convergence.
module spin_commit_unit #(
  parameter  int DATASPIN   = 256,
  parameter  int WORD_WIDTH = 64,
  parameter  int CNT_BIT    = 16,
  localparam int NUM_WORDS  = DATASPIN / WORD_WIDTH,
  localparam int ADDR_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  flush_i,
  input  logic [CNT_BIT-1:0]    stall_limit_i,
  input  logic                  spin_valid_i,
  input  logic [DATASPIN-1:0]   spin_i,
  input  logic                  spin_push_none_i,
  output logic                  spin_ready_o,
  output logic                  wr_valid_o,
  output logic [ADDR_W-1:0]     wr_addr_o,
  output logic [WORD_WIDTH-1:0] wr_data_o,
  input  logic                  wr_ready_i,
  output logic [CNT_BIT-1:0]    commit_cnt_o,
  output logic [CNT_BIT-1:0]    discard_cnt_o,
  output logic                  converged_o,
  output logic                  busy_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  localparam logic [CNT_BIT-1:0] CNT_MAX  = {CNT_BIT{1'b1}};
  localparam logic [ADDR_W-1:0]  LAST_IDX = ADDR_W'(NUM_WORDS - 1);

  state_t                state_r;
  logic [ADDR_W-1:0]     idx_r;
  logic [DATASPIN-1:0]   shadow_r;
  logic [CNT_BIT-1:0]    commit_cnt_r;
  logic [CNT_BIT-1:0]    discard_cnt_r;
  logic [CNT_BIT-1:0]    stall_cnt_r;
  logic                  converged_r;

  logic                  spin_ready_s;
  logic                  spin_hs_s;
  logic                  wr_hs_s;
  logic [CNT_BIT-1:0]    stall_next_s;
  logic [WORD_WIDTH-1:0] wr_data_s;

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_BIT-1:0] sat_inc(input logic [CNT_BIT-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_BIT'(1);
    end
  endfunction

  // Handshake qualification and next stall count.
  always_comb begin
    spin_ready_s = (state_r == ST_IDLE) && en_i && !converged_r && !flush_i;
    spin_hs_s    = spin_valid_i && spin_ready_s;
    wr_hs_s      = (state_r == ST_WRITE) && wr_ready_i;
    stall_next_s = sat_inc(stall_cnt_r);
  end

  // Word select from the captured spin; word 0 holds the LSBs.
  always_comb begin
    wr_data_s = shadow_r[int'(idx_r) * WORD_WIDTH +: WORD_WIDTH];
  end

  // Control FSM, shadow capture and statistics counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= ST_IDLE;
      idx_r         <= '0;
      shadow_r      <= '0;
      commit_cnt_r  <= '0;
      discard_cnt_r <= '0;
      stall_cnt_r   <= '0;
      converged_r   <= 1'b0;
    end else if (flush_i) begin
      // Abandons any partial write; the shadow contents are left as they are.
      state_r       <= ST_IDLE;
      idx_r         <= '0;
      commit_cnt_r  <= '0;
      discard_cnt_r <= '0;
      stall_cnt_r   <= '0;
      converged_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (spin_hs_s) begin
            if (spin_push_none_i) begin
              discard_cnt_r <= sat_inc(discard_cnt_r);
              stall_cnt_r   <= stall_next_s;
              if ((stall_limit_i != '0) && (stall_next_s == stall_limit_i)) begin
                converged_r <= 1'b1;
              end else begin
                converged_r <= converged_r;
              end
            end else begin
              shadow_r    <= spin_i;
              stall_cnt_r <= '0;
              idx_r       <= '0;
              state_r     <= ST_WRITE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (wr_hs_s) begin
            if (idx_r == LAST_IDX) begin
              commit_cnt_r <= sat_inc(commit_cnt_r);
              idx_r        <= '0;
              state_r      <= ST_IDLE;
            end else begin
              idx_r <= idx_r + ADDR_W'(1);
            end
          end else begin
            state_r <= ST_WRITE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= '0;
        end
      endcase
    end
  end

  assign spin_ready_o  = spin_ready_s;
  assign wr_valid_o    = (state_r == ST_WRITE);
  assign busy_o        = (state_r == ST_WRITE);
  assign wr_addr_o     = idx_r;
  assign wr_data_o     = wr_data_s;
  assign commit_cnt_o  = commit_cnt_r;
  assign discard_cnt_o = discard_cnt_r;
  assign converged_o   = converged_r;

endmodule

// File: tb/tb_spin_commit_unit.sv
// Scoreboard bench for spin_commit_unit: stimulus pushes expected write words,
// a negedge monitor pops and compares them on every write handshake.
module tb_spin_commit_unit;

  logic         clk = 1'b0;
  logic         rst, en, flush, spin_valid, spin_none, wr_ready;
  logic [15:0]  stall_limit;
  logic [255:0] spin;
  logic         spin_ready, wr_valid, converged, busy;
  logic [1:0]   wr_addr;
  logic [63:0]  wr_data;
  logic [15:0]  commit_cnt, discard_cnt;

  logic         s_en, s_valid, s_none, s_ready, s_wr_valid, s_conv, s_busy;
  logic [1:0]   s_addr, s_commit, s_discard;
  logic [63:0]  s_data;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]  addr;
    logic [63:0] data;
  } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  spin_commit_unit #(.DATASPIN(256), .WORD_WIDTH(64), .CNT_BIT(16)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush),
    .stall_limit_i(stall_limit), .spin_valid_i(spin_valid), .spin_i(spin),
    .spin_push_none_i(spin_none), .spin_ready_o(spin_ready),
    .wr_valid_o(wr_valid), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .wr_ready_i(wr_ready), .commit_cnt_o(commit_cnt), .discard_cnt_o(discard_cnt),
    .converged_o(converged), .busy_o(busy)
  );

  spin_commit_unit #(.DATASPIN(256), .WORD_WIDTH(64), .CNT_BIT(2)) u_sat (
    .clk_i(clk), .rst_i(rst), .en_i(s_en), .flush_i(1'b0),
    .stall_limit_i(2'd0), .spin_valid_i(s_valid), .spin_i(256'd0),
    .spin_push_none_i(s_none), .spin_ready_o(s_ready),
    .wr_valid_o(s_wr_valid), .wr_addr_o(s_addr), .wr_data_o(s_data),
    .wr_ready_i(1'b1), .commit_cnt_o(s_commit), .discard_cnt_o(s_discard),
    .converged_o(s_conv), .busy_o(s_busy)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] make(input logic [63:0] w0, input logic [63:0] w1,
                                        input logic [63:0] w2, input logic [63:0] w3);
    make = {w3, w2, w1, w0};
  endfunction

  task automatic send_spin(input logic [255:0] d, input logic none);
    int n = 0;
    while (!spin_ready && n < 20) begin
      tick();
      n++;
    end
    chk("spin_accept_wait", spin_ready, 1);
    spin_valid = 1'b1;
    spin       = d;
    spin_none  = none;
    if (!none) begin
      for (int k = 0; k < 4; k++) exp_q.push_back({2'(k), d[k*64 +: 64]});
    end
    tick();
    spin_valid = 1'b0;
    spin_none  = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
  endtask

  // Write-port monitor: stability while stalled, scoreboard compare on accept.
  logic        hold_v = 1'b0;
  logic [1:0]  hold_a;
  logic [63:0] hold_d;
  always @(negedge clk) begin
    if (!rst && !flush && wr_valid) begin
      if (hold_v) begin
        chk("hold_addr", wr_addr, hold_a);
        chk("hold_data", wr_data, hold_d);
      end
      if (wr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: addr %0d data %0h, nothing expected", wr_addr, wr_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
        end
        hold_v = 1'b0;
      end else begin
        hold_v = 1'b1;
        hold_a = wr_addr;
        hold_d = wr_data;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bc;
    rst = 1'b1; en = 1'b0; flush = 1'b0; stall_limit = 16'd0;
    spin_valid = 1'b0; spin = '0; spin_none = 1'b0; wr_ready = 1'b1;
    s_en = 1'b0; s_valid = 1'b0; s_none = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_spin_ready", spin_ready, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_commit", commit_cnt, 0);
    chk("rst_discard", discard_cnt, 0);
    chk("rst_converged", converged, 0);
    chk("rst_wr_data", wr_data, 0);
    en = 1'b1;
    #1;
    chk("en_spin_ready", spin_ready, 1);

    // Basic commit with latency
    send_spin(make(64'd1, 64'd2, 64'd3, 64'd4), 1'b0);
    chk("lat_wr_valid", wr_valid, 1);
    chk("lat_busy", busy, 1);
    chk("lat_addr0", wr_addr, 0);
    chk("lat_data0", wr_data, 1);
    chk("lat_ready_low", spin_ready, 0);
    repeat (3) tick();
    chk("lat_addr3", wr_addr, 3);
    chk("lat_busy3", busy, 1);
    tick();
    chk("commit_ready_back", spin_ready, 1);
    chk("commit_busy", busy, 0);
    chk("commit_cnt", commit_cnt, 1);

    // Backpressure: ready toggles, eight cycles in WRITE
    do_flush();
    chk("flush_commit", commit_cnt, 0);
    wr_ready = 1'b0;
    send_spin(make(64'hA1, 64'hB2, 64'hC3, 64'hD4), 1'b0);
    bc = 0;
    for (int i = 0; i < 8; i++) begin
      wr_ready = (i % 2 == 1);
      if (busy) bc++;
      tick();
    end
    wr_ready = 1'b1;
    chk("bp_busy_cycles", bc, 8);
    chk("bp_busy_done", busy, 0);
    chk("bp_commit", commit_cnt, 1);

    // Convergence after three discards
    do_flush();
    stall_limit = 16'd3;
    send_spin(256'h55, 1'b1);
    send_spin(256'h66, 1'b1);
    chk("conv_not_yet", converged, 0);
    send_spin(256'h77, 1'b1);
    chk("conv_discard", discard_cnt, 3);
    chk("conv_set", converged, 1);
    chk("conv_ready", spin_ready, 0);
    spin_valid = 1'b1;
    repeat (3) tick();
    spin_valid = 1'b0;
    chk("conv_blocked_discard", discard_cnt, 3);
    chk("conv_blocked_busy", busy, 0);
    do_flush();
    chk("flush_conv", converged, 0);
    chk("flush_discard", discard_cnt, 0);

    // Commit clears the stall count
    send_spin(256'h1, 1'b1);
    send_spin(256'h2, 1'b1);
    send_spin(make(64'd5, 64'd6, 64'd7, 64'd8), 1'b0);
    send_spin(256'h3, 1'b1);
    send_spin(256'h4, 1'b1);
    chk("stall_conv", converged, 0);
    chk("stall_discard", discard_cnt, 4);
    chk("stall_commit", commit_cnt, 1);

    // en low does not stall an ongoing write
    do_flush();
    send_spin(make(64'd9, 64'd10, 64'd11, 64'd12), 1'b0);
    en = 1'b0;
    repeat (4) tick();
    chk("en_commit", commit_cnt, 1);
    chk("en_busy", busy, 0);
    chk("en_ready_blocked", spin_ready, 0);
    en = 1'b1;
    #1;
    chk("en_ready_back", spin_ready, 1);

    // Flush mid-write at idx 2
    do_flush();
    stall_limit = 16'd0;
    send_spin(make(64'h11, 64'h12, 64'h13, 64'h14), 1'b0);
    tick();
    tick();
    chk("flush_at_idx2", wr_addr, 2);
    wr_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    chk("flush_wr_valid", wr_valid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_no_commit", commit_cnt, 0);
    wr_ready = 1'b1;
    send_spin(make(64'h21, 64'h22, 64'h23, 64'h24), 1'b0);
    chk("refill_addr0", wr_addr, 0);
    repeat (4) tick();
    chk("refill_commit", commit_cnt, 1);

    // Reset mid-write
    send_spin(make(64'h31, 64'h32, 64'h33, 64'h34), 1'b0);
    tick();
    rst = 1'b1;
    wr_ready = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("rstw_wr_valid", wr_valid, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_commit", commit_cnt, 0);
    chk("rstw_shadow", wr_data, 0);
    wr_ready = 1'b1;

    // Saturation on the 2-bit counter instance
    s_en = 1'b1;
    s_none = 1'b1;
    s_valid = 1'b1;
    repeat (5) tick();
    s_valid = 1'b0;
    chk("sat_discard", s_discard, 3);
    chk("sat_converged", s_conv, 0);
    chk("sat_commit", s_commit, 0);
    chk("sat_ready", s_ready, 1);

    tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spin_commit_unit.md
SPIN_COMMIT_UNIT -- requirements
Module: spin_commit_unit

Interface
REQ-001 SHALL have parameter DATASPIN, default 256, spin vector width.
REQ-002 SHALL have parameter WORD_WIDTH, default 64, write-port word width; DATASPIN SHALL be an integer multiple of WORD_WIDTH (NUM_WORDS = DATASPIN/WORD_WIDTH).
REQ-003 SHALL have parameter CNT_BIT, default 16, width of stall limit and all counters.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports (name  direction  width  meaning):
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
en_i  in  1  enables acceptance of new spins
flush_i  in  1  synchronous soft clear
stall_limit_i  in  CNT_BIT  consecutive-discard threshold; 0 disables convergence
spin_valid_i  in  1  upstream spin valid
spin_i  in  DATASPIN  upstream spin vector
spin_push_none_i  in  1  qualifier: spin not better, discard
spin_ready_o  out  1  spin accept
wr_valid_o  out  1  write request valid
wr_addr_o  out  max(1,$clog2(NUM_WORDS))  word index
wr_data_o  out  WORD_WIDTH  word data
wr_ready_i  in  1  write accept
commit_cnt_o  out  CNT_BIT  committed spins
discard_cnt_o  out  CNT_BIT  discarded spins
converged_o  out  1  stall threshold reached
busy_o  out  1  FSM in WRITE

Function
REQ-006 SHALL implement FSM with states IDLE and WRITE.
REQ-007 spin_ready_o SHALL be 1 only in IDLE with en_i=1, converged_o=0, flush_i=0; purely combinational from state and these inputs.
REQ-008 Spin handshake = spin_valid_i & spin_ready_o; spin_i and spin_push_none_i sampled only on handshake.
REQ-009 Handshake with spin_push_none_i=1: discard_cnt_o +1, stall counter +1, FSM stays IDLE, no write issued.
REQ-010 Handshake with spin_push_none_i=0: spin_i captured into shadow register, stall counter cleared to 0, word index cleared to 0, FSM -> WRITE next cycle.
REQ-011 In WRITE: wr_valid_o=1, wr_addr_o=word index, wr_data_o=shadow[idx*WORD_WIDTH +: WORD_WIDTH] (word 0 = LSBs).
REQ-012 wr_valid_o, wr_addr_o, wr_data_o SHALL stay stable until wr_valid_o & wr_ready_i.
REQ-013 On write handshake with idx<NUM_WORDS-1: idx +1, stay WRITE.
REQ-014 On write handshake with idx=NUM_WORDS-1: commit_cnt_o +1, FSM -> IDLE.
REQ-015 Latency: spin handshake in cycle t -> wr_valid_o=1 in cycle t+1; with wr_ready_i tied 1, full commit takes NUM_WORDS cycles, spin_ready_o back to 1 in cycle t+NUM_WORDS+1.
REQ-016 en_i=0 SHALL block new spins in IDLE but SHALL NOT stall an ongoing WRITE.
REQ-017 converged_o SHALL set in the cycle after a discard brings stall counter to stall_limit_i when stall_limit_i!=0; remains set until flush_i or rst_i.
REQ-018 stall_limit_i=0: converged_o never sets; stall counter still counts.
REQ-019 commit_cnt_o, discard_cnt_o, stall counter SHALL saturate at 2^CNT_BIT-1, no wrap.
REQ-020 flush_i=1 (any state): next cycle FSM=IDLE, idx=0, stall counter=0, converged_o=0, commit_cnt_o=0, discard_cnt_o=0; an in-progress WRITE is abandoned without incrementing commit_cnt_o; flush has priority over any simultaneous handshake.
REQ-021 busy_o=1 exactly when FSM is WRITE.

Reset
REQ-022 rst_i=1 at a clock edge: FSM=IDLE, idx=0, shadow=0, all counters=0, converged_o=0, wr_valid_o=0, busy_o=0; rst_i has priority over flush_i and all handshakes.
REQ-023 Reset asserted mid-WRITE SHALL drop wr_valid_o the next cycle with no commit counted.

Verification (DATASPIN=256, WORD_WIDTH=64)
REQ-024 Commit: en_i=1, wr_ready_i=1, spin_i=256'h0004_..._0003_..._0002_..._0001 (word k = k+1), push_none=0 -> wr_addr 0..3 on cycles t+1..t+4 with data 1,2,3,4; commit_cnt_o=1; spin_ready_o=1 at t+5.
REQ-025 Backpressure: wr_ready_i toggles 0,1 each cycle -> each word held stable until accepted; 8 cycles in WRITE; commit_cnt_o=1.
REQ-026 Convergence: stall_limit_i=3, three push_none spins -> discard_cnt_o=3, converged_o=1, spin_ready_o=0; fourth spin_valid_i not accepted.
REQ-027 Stall reset: stall_limit_i=3, sequence discard, discard, commit, discard, discard -> converged_o stays 0, discard_cnt_o=4, commit_cnt_o=1.
REQ-028 Flush mid-WRITE: flush_i at idx=2 -> next cycle wr_valid_o=0, busy_o=0, commit_cnt_o=0; subsequent spin commits normally from idx 0.
REQ-029 Saturation: CNT_BIT=2, five discards with stall_limit_i=0 -> discard_cnt_o=3, converged_o=0.
